// File: rtl/exe_stage_if.sv
// ID/EX-to-EX/MEM bundle for the execute stage: pipeline inputs, branch resolution and EX/MEM outputs.
interface exe_stage_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
);
  // ID/EX pipeline register outputs
  logic              WB_En_in;
  logic              MEM_R_En_in;
  logic              MEM_W_En_in;
  logic [1:0]        BR_Type_in;
  logic [3:0]        EXE_Cmd_in;
  logic [ADDR_W-1:0] dest_in;
  logic [DATA_W-1:0] readdata1_in;
  logic [DATA_W-1:0] readdata2_in;
  logic [DATA_W-1:0] Immediate_in;
  logic [DATA_W-1:0] data1_in;
  logic [DATA_W-1:0] data2_in;
  logic [DATA_W-1:0] PC_in;

  // Combinational hazard / branch signals
  logic              Br_taken;
  logic [DATA_W-1:0] Br_Addr;
  logic              Freeze;

  // EX/MEM register
  logic              WB_En;
  logic              MEM_R_En;
  logic              MEM_W_En;
  logic [ADDR_W-1:0] dest;
  logic [DATA_W-1:0] ALU_Res;
  logic [DATA_W-1:0] ST_Val;

  // Upstream driver / downstream consumer side
  modport master (
    output WB_En_in, MEM_R_En_in, MEM_W_En_in, BR_Type_in, EXE_Cmd_in, dest_in,
           readdata1_in, readdata2_in, Immediate_in, data1_in, data2_in, PC_in,
    input  Br_taken, Br_Addr, Freeze, WB_En, MEM_R_En, MEM_W_En, dest, ALU_Res, ST_Val
  );

  // Execute stage side
  modport slave (
    input  WB_En_in, MEM_R_En_in, MEM_W_En_in, BR_Type_in, EXE_Cmd_in, dest_in,
           readdata1_in, readdata2_in, Immediate_in, data1_in, data2_in, PC_in,
    output Br_taken, Br_Addr, Freeze, WB_En, MEM_R_En, MEM_W_En, dest, ALU_Res, ST_Val
  );
endinterface

// File: rtl/exe_stage.sv
// MIPS execute stage: single-cycle ALU, combinational branch resolution,
// 32-step shift-add multiplier that freezes upstream, and the EX/MEM register.
module exe_stage #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic        clk,
  input  logic        rst,
  exe_stage_if.slave  bus
);

  localparam int unsigned CNT_W   = 5;
  localparam int unsigned SHAMT_W = 5;

  localparam logic [3:0] CMD_ADD = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_AND = 4'b0100;
  localparam logic [3:0] CMD_OR  = 4'b0101;
  localparam logic [3:0] CMD_NOR = 4'b0110;
  localparam logic [3:0] CMD_XOR = 4'b0111;
  localparam logic [3:0] CMD_SLL = 4'b1000;
  localparam logic [3:0] CMD_SRL = 4'b1001;
  localparam logic [3:0] CMD_SRA = 4'b1010;
  localparam logic [3:0] CMD_MUL = 4'b1100;

  localparam logic [1:0] BR_BEZ = 2'b01;
  localparam logic [1:0] BR_BNE = 2'b10;
  localparam logic [1:0] BR_JMP = 2'b11;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(31);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t              state, state_nxt;
  logic [DATA_W-1:0]   mcand, mcand_nxt;
  logic [DATA_W-1:0]   mplier, mplier_nxt;
  logic [DATA_W-1:0]   acc, acc_nxt;
  logic [CNT_W-1:0]    cnt, cnt_nxt;

  logic                wb_en_q, wb_en_nxt;
  logic                mem_r_en_q, mem_r_en_nxt;
  logic                mem_w_en_q, mem_w_en_nxt;
  logic [ADDR_W-1:0]   dest_q, dest_nxt;
  logic [DATA_W-1:0]   alu_res_q, alu_res_nxt;
  logic [DATA_W-1:0]   st_val_q, st_val_nxt;

  logic [DATA_W-1:0]   alu_res_c;
  logic [SHAMT_W-1:0]  shamt_c;
  logic                is_mul_c;
  logic                freeze_c;

  assign shamt_c  = bus.data2_in[SHAMT_W-1:0];
  assign is_mul_c = (bus.EXE_Cmd_in == CMD_MUL);

  // Single-cycle ALU; MUL and unused codes produce 0 here
  always_comb begin
    alu_res_c = '0;
    case (bus.EXE_Cmd_in)
      CMD_ADD: alu_res_c = bus.data1_in + bus.data2_in;
      CMD_SUB: alu_res_c = bus.data1_in - bus.data2_in;
      CMD_AND: alu_res_c = bus.data1_in & bus.data2_in;
      CMD_OR:  alu_res_c = bus.data1_in | bus.data2_in;
      CMD_NOR: alu_res_c = ~(bus.data1_in | bus.data2_in);
      CMD_XOR: alu_res_c = bus.data1_in ^ bus.data2_in;
      CMD_SLL: alu_res_c = bus.data1_in << shamt_c;
      CMD_SRL: alu_res_c = bus.data1_in >> shamt_c;
      CMD_SRA: alu_res_c = DATA_W'($signed(bus.data1_in) >>> shamt_c);
      default: alu_res_c = '0;
    endcase
  end

  // Branch resolution is independent of the multiplier freeze
  assign bus.Br_Addr  = bus.PC_in + (bus.Immediate_in << 2);
  assign bus.Br_taken = ((bus.BR_Type_in == BR_BEZ) && (bus.readdata1_in == '0)) ||
                        ((bus.BR_Type_in == BR_BNE) && (bus.readdata1_in != bus.readdata2_in)) ||
                        (bus.BR_Type_in == BR_JMP);

  // State, multiplier datapath and EX/MEM register
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      mcand      <= '0;
      mplier     <= '0;
      acc        <= '0;
      cnt        <= '0;
      wb_en_q    <= 1'b0;
      mem_r_en_q <= 1'b0;
      mem_w_en_q <= 1'b0;
      dest_q     <= '0;
      alu_res_q  <= '0;
      st_val_q   <= '0;
    end else begin
      state      <= state_nxt;
      mcand      <= mcand_nxt;
      mplier     <= mplier_nxt;
      acc        <= acc_nxt;
      cnt        <= cnt_nxt;
      wb_en_q    <= wb_en_nxt;
      mem_r_en_q <= mem_r_en_nxt;
      mem_w_en_q <= mem_w_en_nxt;
      dest_q     <= dest_nxt;
      alu_res_q  <= alu_res_nxt;
      st_val_q   <= st_val_nxt;
    end
  end

  // Next state, multiplier step and EX/MEM load; default load is a bubble
  always_comb begin
    state_nxt    = state;
    mcand_nxt    = mcand;
    mplier_nxt   = mplier;
    acc_nxt      = acc;
    cnt_nxt      = cnt;
    wb_en_nxt    = 1'b0;
    mem_r_en_nxt = 1'b0;
    mem_w_en_nxt = 1'b0;
    dest_nxt     = '0;
    alu_res_nxt  = '0;
    st_val_nxt   = '0;
    freeze_c     = 1'b0;

    case (state)
      IDLE: begin
        if (is_mul_c) begin
          freeze_c   = 1'b1;
          mcand_nxt  = bus.data1_in;
          mplier_nxt = bus.data2_in;
          acc_nxt    = '0;
          cnt_nxt    = '0;
          state_nxt  = BUSY;
        end else begin
          wb_en_nxt    = bus.WB_En_in;
          mem_r_en_nxt = bus.MEM_R_En_in;
          mem_w_en_nxt = bus.MEM_W_En_in;
          dest_nxt     = bus.dest_in;
          alu_res_nxt  = alu_res_c;
          st_val_nxt   = bus.readdata2_in;
        end
      end
      BUSY: begin
        freeze_c   = 1'b1;
        acc_nxt    = acc + (mplier[0] ? mcand : '0);
        mcand_nxt  = mcand << 1;
        mplier_nxt = mplier >> 1;
        cnt_nxt    = cnt + CNT_W'(1);
        if (cnt == CNT_LAST) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        wb_en_nxt    = bus.WB_En_in;
        mem_r_en_nxt = bus.MEM_R_En_in;
        mem_w_en_nxt = bus.MEM_W_En_in;
        dest_nxt     = bus.dest_in;
        alu_res_nxt  = acc;
        st_val_nxt   = bus.readdata2_in;
        state_nxt    = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    if (rst) begin
      freeze_c = 1'b0;
    end
  end

  assign bus.Freeze   = freeze_c;
  assign bus.WB_En    = wb_en_q;
  assign bus.MEM_R_En = mem_r_en_q;
  assign bus.MEM_W_En = mem_w_en_q;
  assign bus.dest     = dest_q;
  assign bus.ALU_Res  = alu_res_q;
  assign bus.ST_Val   = st_val_q;

endmodule
